// File: rtl/se_sram_srw_clr.sv
// Single-port SRAM with per-lane write enables and a hardware clear engine that fills every word after reset or on request.
// Optional build macro SE_SRAM_SRW_CLR_OUTREG_EN adds an output register stage, so read latency becomes 2.
module se_sram_srw_clr #(
  parameter int                    address_width = 10,
  parameter int                    data_width    = 32,
  parameter int                    lane_width    = 8,
  parameter logic [data_width-1:0] clear_value   = '0
) (
  input  logic                                sram_clock,
  input  logic                                reset_n,
  input  logic                                sram_clock__enable,
  input  logic                                select,
  input  logic                                read_not_write,
  input  logic [data_width/lane_width-1:0]    write_enable,
  input  logic [address_width-1:0]            address,
  input  logic [data_width-1:0]               write_data,
  input  logic                                clear_request,
  output logic [data_width-1:0]               data_out,
  output logic                                data_valid,
  output logic                                busy
);

  localparam int lanes = data_width / lane_width;
  localparam int depth = 1 << address_width;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                   r_state, w_state_nxt;
  logic [address_width-1:0] r_cnt, w_cnt_nxt;
  logic [data_width-1:0]    r_mem [depth];
  logic [lanes-1:0]         w_mem_we;
  logic [address_width-1:0] w_mem_addr;
  logic [data_width-1:0]    w_mem_wdata;
  logic                     w_rd;
  logic [data_width-1:0]    r_rd_dat;
  logic                     r_rd_vld;

  // A clear request outranks both the clear sweep and any access in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mem_we    = '0;
    w_mem_addr  = address;
    w_mem_wdata = write_data;
    w_rd        = 1'b0;
    if (clear_request) begin
      w_state_nxt = CLEAR;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        CLEAR: begin
          w_mem_we    = '1;
          w_mem_addr  = r_cnt;
          w_mem_wdata = clear_value;
          w_cnt_nxt   = r_cnt + address_width'(1);
          if (&r_cnt) w_state_nxt = READY;
        end
        READY: begin
          if (select) begin
            if (read_not_write) w_rd = 1'b1;
            else                w_mem_we = write_enable;
          end
        end
        default: w_state_nxt = CLEAR;
      endcase
    end
  end

  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else if (sram_clock__enable) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge sram_clock) begin
    if (sram_clock__enable) begin
      for (int i = 0; i < lanes; i++) begin
        if (w_mem_we[i])
          r_mem[w_mem_addr][i*lane_width +: lane_width] <= w_mem_wdata[i*lane_width +: lane_width];
      end
    end
  end

  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_dat <= '0;
      r_rd_vld <= 1'b0;
    end else if (sram_clock__enable) begin
      r_rd_vld <= w_rd;
      if (w_rd) r_rd_dat <= r_mem[address];
    end
  end

`ifdef SE_SRAM_SRW_CLR_OUTREG_EN
  logic [data_width-1:0] r_out_dat;
  logic                  r_out_vld;

  // A clear request flushes any read still in flight through the output stage.
  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_dat <= '0;
      r_out_vld <= 1'b0;
    end else if (sram_clock__enable) begin
      r_out_vld <= r_rd_vld & ~clear_request;
      if (r_rd_vld) r_out_dat <= r_rd_dat;
    end
  end

  assign data_out   = r_out_dat;
  assign data_valid = r_out_vld;
`else
  assign data_out   = r_rd_dat;
  assign data_valid = r_rd_vld;
`endif

  assign busy = (r_state == CLEAR);

endmodule

// File: tb/tb_se_sram_srw_clr.sv
// Directed self-checking bench for se_sram_srw_clr (address_width=4, 32-bit words, 8-bit lanes).
module tb_se_sram_srw_clr;

`ifdef SE_SRAM_SRW_CLR_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        sram_clock = 1'b0;
  logic        reset_n;
  logic        sram_clock__enable;
  logic        select;
  logic        read_not_write;
  logic [3:0]  write_enable;
  logic [3:0]  address;
  logic [31:0] write_data;
  logic        clear_request;
  logic [31:0] data_out;
  logic        data_valid;
  logic        busy;

  int total = 0;
  int bad   = 0;

  se_sram_srw_clr #(
    .address_width(4),
    .data_width   (32),
    .lane_width   (8),
    .clear_value  (32'h0)
  ) dut (
    .sram_clock        (sram_clock),
    .reset_n           (reset_n),
    .sram_clock__enable(sram_clock__enable),
    .select            (select),
    .read_not_write    (read_not_write),
    .write_enable      (write_enable),
    .address           (address),
    .write_data        (write_data),
    .clear_request     (clear_request),
    .data_out          (data_out),
    .data_valid        (data_valid),
    .busy              (busy)
  );

  always #5 sram_clock = ~sram_clock;

  task automatic tick;
    @(posedge sram_clock);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] we);
    select = 1'b1; read_not_write = 1'b0; address = a; write_data = d; write_enable = we;
    tick();
    select = 1'b0;
  endtask

  // Returns data/valid at the expected latency, and valid one cycle later.
  task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic v, output logic va);
    select = 1'b1; read_not_write = 1'b1; address = a;
    tick();
    select = 1'b0;
    repeat (LAT - 1) tick();
    d = data_out; v = data_valid;
    tick();
    va = data_valid;
  endtask

  task automatic test_reset;
    int bc;
    logic [31:0] d; logic v, va;
    reset_n = 1'b0;
    tick(); tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
    total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset_dout got=%h exp=00000000", data_out); end
    reset_n = 1'b1;
    bc = 0;
    while (busy && bc < 100) begin bc++; tick(); end
    total++; if (bc != 16) begin bad++; $display("FAIL reset_clear_cycles got=%0d exp=16", bc); end
    for (int i = 0; i < 16; i++) begin
      do_read(4'(i), d, v, va);
      total++;
      if (d !== 32'h0 || v !== 1'b1 || va !== 1'b0) begin
        bad++; $display("FAIL clear_read a=%0d got=%h/%b/%b exp=00000000/1/0", i, d, v, va);
      end
    end
  endtask

  task automatic test_full_write;
    logic [31:0] d; logic v, va;
    do_write(4'd3, 32'hDEADBEEF, 4'hF);
    do_read(4'd3, d, v, va);
    total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL full_write_data got=%h exp=deadbeef", d); end
    total++; if (v !== 1'b1 || va !== 1'b0) begin bad++; $display("FAIL full_write_valid got=%b%b exp=10", v, va); end
  endtask

  task automatic test_lane_write;
    logic [31:0] d; logic v, va;
    do_write(4'd3, 32'h11223344, 4'b0101);
    do_read(4'd3, d, v, va);
    total++; if (d !== 32'hDE22BE44) begin bad++; $display("FAIL lane_write got=%h exp=de22be44", d); end
    do_write(4'd3, 32'h99999999, 4'b0000);
    do_read(4'd3, d, v, va);
    total++; if (d !== 32'hDE22BE44) begin bad++; $display("FAIL zero_we_write got=%h exp=de22be44", d); end
  endtask

  task automatic test_enable_hold;
    logic [31:0] d; logic v, va;
    sram_clock__enable = 1'b0;
    do_write(4'd9, 32'hFFFFFFFF, 4'hF);
    select = 1'b1; read_not_write = 1'b1; address = 4'd9;
    tick(); tick();
    select = 1'b0;
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL stalled_read_valid got=%b exp=0", data_valid); end
    sram_clock__enable = 1'b1;
    do_read(4'd9, d, v, va);
    total++; if (d !== 32'h0 || v !== 1'b1) begin bad++; $display("FAIL stalled_write got=%h/%b exp=00000000/1", d, v); end
  endtask

  task automatic test_back_to_back;
    logic exp_v;
    logic [31:0] exp_d;
    do_write(4'd3, 32'hCAFEF00D, 4'hF);
    do_write(4'd4, 32'h12345678, 4'hF);
    select = 1'b1; read_not_write = 1'b1; address = 4'd3;
    tick();
    for (int s = 0; s < 4; s++) begin
      if (s == 0) address = 4'd4;
      else        select = 1'b0;
      exp_v = (s == LAT - 1) || (s == LAT);
      exp_d = (s >= LAT) ? 32'h12345678 : 32'hCAFEF00D;
      total++;
      if (data_valid !== exp_v || (exp_v && data_out !== exp_d)) begin
        bad++; $display("FAIL b2b_read s=%0d got=%h/%b exp=%h/%b", s, data_out, data_valid, exp_d, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_stall_clear;
    int bc;
    logic vseen;
    logic [31:0] d; logic v, va;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bc = 0; vseen = 1'b0;
    while (busy && bc < 100) begin
      bc++;
      sram_clock__enable = !(bc >= 4 && bc <= 8);
      if (bc == 10) begin
        select = 1'b1; read_not_write = 1'b0; address = 4'd5; write_data = 32'hFFFFFFFF; write_enable = 4'hF;
      end else begin
        select = 1'b0;
      end
      tick();
      if (data_valid) vseen = 1'b1;
    end
    sram_clock__enable = 1'b1; select = 1'b0;
    total++; if (bc != 21) begin bad++; $display("FAIL stall_clear_cycles got=%0d exp=21", bc); end
    total++; if (vseen !== 1'b0) begin bad++; $display("FAIL stall_clear_valid got=%b exp=0", vseen); end
    do_read(4'd5, d, v, va);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL busy_write_dropped got=%h exp=00000000", d); end
  endtask

  task automatic test_clear_restart;
    int bc;
    logic vseen;
    logic [31:0] d; logic v, va;
    do_write(4'd7, 32'hA5A5A5A5, 4'hF);
    do_read(4'd7, d, v, va);
    total++; if (d !== 32'hA5A5A5A5) begin bad++; $display("FAIL restart_prefill got=%h exp=a5a5a5a5", d); end
    clear_request = 1'b1; select = 1'b1; read_not_write = 1'b1; address = 4'd7;
    tick();
    clear_request = 1'b0; select = 1'b0;
    vseen = data_valid;
    bc = 0;
    while (busy && bc < 100) begin
      bc++;
      clear_request = (bc == 4);
      tick();
      if (data_valid) vseen = 1'b1;
    end
    clear_request = 1'b0;
    total++; if (bc != 20) begin bad++; $display("FAIL restart_cycles got=%0d exp=20", bc); end
    total++; if (vseen !== 1'b0) begin bad++; $display("FAIL restart_valid got=%b exp=0", vseen); end
    total++; if (data_out !== 32'hA5A5A5A5) begin bad++; $display("FAIL restart_dout_hold got=%h exp=a5a5a5a5", data_out); end
    do_read(4'd7, d, v, va);
    total++; if (d !== 32'h0 || v !== 1'b1) begin bad++; $display("FAIL restart_read got=%h/%b exp=00000000/1", d, v); end
  endtask

  initial begin
    reset_n = 1'b0; sram_clock__enable = 1'b1; select = 1'b0; read_not_write = 1'b0;
    write_enable = '0; address = '0; write_data = '0; clear_request = 1'b0;
    test_reset();
    test_full_write();
    test_lane_write();
    test_enable_hold();
    test_back_to_back();
    test_stall_clear();
    test_clear_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
